// File: rtl/ccx_emem_bridge.sv
// ccx_emem_bridge: converts the core's single-phase req/gnt memory port into a split request/response bus.
// One transaction in flight. The completion watchdog and DRAIN path exist only when CCX_EMEM_TIMEOUT_EN is defined.
module ccx_emem_bridge #(
  parameter int          AW             = 39,
  parameter int          DW             = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            s_req,
  input  logic [AW-1:0]   s_addr,
  input  logic            s_wen,
  input  logic [DW/8-1:0] s_strb,
  input  logic [DW-1:0]   s_wdata,
  output logic            s_gnt,
  output logic            s_err,
  output logic [DW-1:0]   s_rdata,
  output logic            m_req,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ack,
  input  logic            m_rvalid,
  input  logic            m_rerr,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy,
  output logic            tmo_evt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t            r_state;
  logic              r_to_drain;
  logic              r_m_req;
  logic [AW-1:0]     r_m_addr;
  logic              r_m_wen;
  logic [DW/8-1:0]   r_m_strb;
  logic [DW-1:0]     r_m_wdata;
  logic              r_s_gnt;
  logic              r_s_err;
  logic [DW-1:0]     r_s_rdata;
  logic              r_busy;
  logic              r_tmo_evt;
  logic              w_expire;

`ifdef CCX_EMEM_TIMEOUT_EN
  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Saturates at LIMIT so an ack on the expiry cycle still expires on the first WAIT cycle.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_REQ, ST_WAIT, ST_DRAIN: if (r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
        default:                   r_cnt <= '0;
      endcase
    end
  end

  assign w_expire = (r_cnt == LIMIT);
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
  assign w_expire     = 1'b0;
`endif

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state    <= ST_IDLE;
      r_to_drain <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_addr   <= '0;
      r_m_wen    <= 1'b0;
      r_m_strb   <= '0;
      r_m_wdata  <= '0;
      r_s_gnt    <= 1'b0;
      r_s_err    <= 1'b0;
      r_s_rdata  <= '0;
      r_busy     <= 1'b0;
      r_tmo_evt  <= 1'b0;
    end else begin
      r_s_gnt   <= 1'b0;
      r_s_err   <= 1'b0;
      r_tmo_evt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_req) begin
            r_m_addr  <= s_addr;
            r_m_wen   <= s_wen;
            r_m_strb  <= s_strb;
            r_m_wdata <= s_wdata;
            r_m_req   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_ack) begin
            r_m_req <= 1'b0;
            if (m_rvalid) begin
              r_s_rdata <= m_rdata;
              r_s_err   <= m_rerr;
              r_s_gnt   <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end else if (w_expire) begin
            // Nothing accepted the request, so it is simply abandoned.
            r_m_req   <= 1'b0;
            r_s_rdata <= '0;
            r_s_err   <= 1'b1;
            r_s_gnt   <= 1'b1;
            r_tmo_evt <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (m_rvalid) begin
            r_s_rdata <= m_rdata;
            r_s_err   <= m_rerr;
            r_s_gnt   <= 1'b1;
            r_state   <= ST_RESP;
          end else if (w_expire) begin
            // The fabric owes us a response; swallow it in DRAIN so it cannot hit the next request.
            r_s_rdata  <= '0;
            r_s_err    <= 1'b1;
            r_s_gnt    <= 1'b1;
            r_tmo_evt  <= 1'b1;
            r_to_drain <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_to_drain <= 1'b0;
          if (r_to_drain) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (m_rvalid || w_expire) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_gnt   = r_s_gnt;
  assign s_err   = r_s_err;
  assign s_rdata = r_s_rdata;
  assign m_req   = r_m_req;
  assign m_addr  = r_m_addr;
  assign m_wen   = r_m_wen;
  assign m_strb  = r_m_strb;
  assign m_wdata = r_m_wdata;
  assign busy    = r_busy;
  assign tmo_evt = r_tmo_evt;

endmodule
